tl_flow_controller: RTL and testbench

Sequencing and flow-control controller for the transaction-layer datapath: one 12-bit input FIFO fanning out to four 8-deep output FIFOs (P0..P3).
- Latches low/high occupancy thresholds during init.
- Pops the input FIFO and routes each word to the port selected by bits [11:10].
- Stalls per-port at the high threshold and drives a hysteretic pause to upstream.
- Sits between the FIFO bank and the probador/top, replacing ad-hoc pop/push driving.

---
 rtl/tl_pkg.sv | 19 +
 rtl/tl_pause_hyst.sv | 34 +++
 rtl/tl_flow_controller.sv | 126 ++++++++++++
 tb/tb_tl_flow_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// tl_pkg: shared widths, destination field position and one-hot FSM encoding
// for the transaction-layer flow controller.
package tl_pkg;
   localparam int DATA_W   = 12;
   localparam int DEPTH    = 8;
   localparam int CNT_W    = 4;
   localparam int TH_W     = 3;
   localparam int NPORT    = 4;
   localparam int DEST_MSB = DATA_W - 1;
   localparam int DEST_LSB = DATA_W - 2;

   typedef enum logic [4:0] {
      ST_RESET  = 5'b00001,
      ST_INIT   = 5'b00010,
      ST_IDLE   = 5'b00100,
      ST_ACTIVE = 5'b01000,
      ST_ERROR  = 5'b10000
   } state_e;
endpackage

// File: rtl/tl_pause_hyst.sv
// tl_pause_hyst: upstream pause with hysteresis between the low and high
// occupancy thresholds across all output ports.
module tl_pause_hyst
   import tl_pkg::*;
#(
   parameter int CW = CNT_W,
   parameter int TW = TH_W,
   parameter int NP = NPORT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [NP*CW-1:0] cnt_i,
   input  logic [TW-1:0]    lo_i,
   input  logic [TW-1:0]    hi_i,
   output logic             pause_o
);
   logic any_hi, all_lo, pause_q;

   always_comb begin
      any_hi = 1'b0;
      all_lo = 1'b1;
      for (int p = 0; p < NP; p++) begin
         any_hi = any_hi | (cnt_i[p*CW +: CW] >= CW'(hi_i));
         all_lo = all_lo & (cnt_i[p*CW +: CW] <= CW'(lo_i));
      end
   end

   // setting wins, so a low threshold at or above the high one still behaves
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) pause_q <= 1'b0;
      else         pause_q <= any_hi ? 1'b1 : (all_lo ? 1'b0 : pause_q);

   assign pause_o = pause_q;
endmodule

// File: rtl/tl_flow_controller.sv
// tl_flow_controller: routes input FIFO words to four output FIFOs with
// per-port stalling and upstream pause; TLC_STATS_EN adds per-port push counters.
module tl_flow_controller
   import tl_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                init_i,
   input  logic [TH_W-1:0]     umbral_bajo_i,
   input  logic [TH_W-1:0]     umbral_alto_i,
   input  logic                in_empty_i,
   input  logic [DATA_W-1:0]   in_data_i,
   output logic                in_pop_o,
   input  logic [4*CNT_W-1:0]  out_count_i,
   input  logic [4:0]          fifo_error_i,
   output logic [3:0]          out_push_o,
   output logic [DATA_W-1:0]   out_data_o,
   output logic [TH_W-1:0]     umbral_bajo_o,
   output logic [TH_W-1:0]     umbral_alto_o,
   output logic                pause_o,
   output logic [4:0]          state_o,
   output logic                idle_o,
   output logic                error_out_o,
   input  logic [1:0]          idx_i,
   input  logic                req_i,
   output logic [4:0]          counter_out_o,
   output logic                counter_valid_o
);
   state_e              state_q, state_d;
   logic [TH_W-1:0]     bajo_q, alto_q;
   logic [3:0]          push_q, push_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CNT_W-1:0]    cnt_a [4];
   logic [1:0]          dest;
   logic [CNT_W:0]      eff_cnt;
   logic                err, pop;

   for (genvar g = 0; g < 4; g++) begin : g_cnt
      assign cnt_a[g] = out_count_i[g*CNT_W +: CNT_W];
   end

   // a push issued last cycle is not yet in the FIFO count, so add it back
   assign dest    = in_data_i[DEST_MSB:DEST_LSB];
   assign err     = |fifo_error_i;
   assign eff_cnt = {1'b0, cnt_a[dest]} + {{CNT_W{1'b0}}, push_q[dest]};
   assign pop     = (state_q == ST_ACTIVE) && !in_empty_i && !err &&
                    (eff_cnt < (CNT_W+1)'(alto_q));
   assign push_d  = pop ? 4'(1 << dest) : 4'b0;
   assign data_d  = pop ? in_data_i : data_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:  state_d = ST_INIT;
         ST_INIT:   state_d = init_i ? ST_INIT : ST_IDLE;
         ST_IDLE:   state_d = init_i ? ST_INIT : (in_empty_i ? ST_IDLE : ST_ACTIVE);
         ST_ACTIVE: state_d = init_i ? ST_INIT :
                              ((in_empty_i && push_q == 4'b0) ? ST_IDLE : ST_ACTIVE);
         ST_ERROR:  state_d = init_i ? ST_INIT : ST_ERROR;
         default:   state_d = ST_RESET;
      endcase
      if (err && state_q != ST_RESET && state_q != ST_INIT) state_d = ST_ERROR;
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q <= ST_RESET;
         bajo_q  <= '0;
         alto_q  <= '0;
         push_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         push_q  <= push_d;
         data_q  <= data_d;
         if (state_q == ST_INIT) begin
            bajo_q <= umbral_bajo_i;
            alto_q <= umbral_alto_i;
         end
      end

   tl_pause_hyst u_pause (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .cnt_i   (out_count_i),
      .lo_i    (bajo_q),
      .hi_i    (alto_q),
      .pause_o (pause_o)
   );

   assign in_pop_o      = pop;
   assign out_push_o    = push_q;
   assign out_data_o    = data_q;
   assign umbral_bajo_o = bajo_q;
   assign umbral_alto_o = alto_q;
   assign state_o       = state_q;
   assign idle_o        = (state_q == ST_IDLE) && in_empty_i;
   assign error_out_o   = (state_q == ST_ERROR);

`ifdef TLC_STATS_EN
   logic [4:0] stat_q [4];
   logic [4:0] cout_q;
   logic       cval_q;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         for (int p = 0; p < 4; p++) stat_q[p] <= '0;
         cout_q <= '0;
         cval_q <= 1'b0;
      end else begin
         for (int p = 0; p < 4; p++)
            stat_q[p] <= (state_q == ST_RESET || state_q == ST_INIT) ? 5'd0 :
                         (push_q[p] && stat_q[p] != 5'd31) ? stat_q[p] + 5'd1 : stat_q[p];
         cval_q <= req_i;
         if (req_i) cout_q <= stat_q[idx_i];
      end

   assign counter_out_o   = cout_q;
   assign counter_valid_o = cval_q;
`else
   logic stats_unused;
   assign stats_unused    = ^{idx_i, req_i};
   assign counter_out_o   = '0;
   assign counter_valid_o = 1'b0;
`endif
endmodule

// File: tb/tb_tl_flow_controller.sv
// tb_tl_flow_controller: table-driven cycle vectors with a push scoreboard,
// plus hand-written reset, stats and mid-transfer reset sequences.
module tb_tl_flow_controller;
   localparam logic [4:0] S_R = 5'b00001, S_I = 5'b00010, S_D = 5'b00100,
                          S_A = 5'b01000, S_E = 5'b10000;

   logic        clk, rst_n, init, in_empty, in_pop, pause, idle, error_out, req, counter_valid;
   logic [2:0]  bajo_in, alto_in, umbral_bajo, umbral_alto;
   logic [11:0] in_data, out_data;
   logic [15:0] out_count;
   logic [4:0]  fifo_error, state, counter_out;
   logic [3:0]  out_push;
   logic [1:0]  idx;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        init, empty;
      logic [11:0] data;
      logic [15:0] cnt;
      logic [4:0]  err;
      logic [2:0]  bajo, alto;
      logic [4:0]  st;
      logic        pop, pause;
      logic [2:0]  eb, ea;
   } vec_t;

   typedef struct {
      logic [3:0]  push;
      logic [11:0] data;
   } sb_t;

   vec_t tv[$];
   sb_t  sb[$];

   tl_flow_controller dut (
      .clk_i(clk), .rst_ni(rst_n), .init_i(init),
      .umbral_bajo_i(bajo_in), .umbral_alto_i(alto_in),
      .in_empty_i(in_empty), .in_data_i(in_data), .in_pop_o(in_pop),
      .out_count_i(out_count), .fifo_error_i(fifo_error),
      .out_push_o(out_push), .out_data_o(out_data),
      .umbral_bajo_o(umbral_bajo), .umbral_alto_o(umbral_alto),
      .pause_o(pause), .state_o(state), .idle_o(idle), .error_out_o(error_out),
      .idx_i(idx), .req_i(req), .counter_out_o(counter_out), .counter_valid_o(counter_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic v(input logic i, input logic e, input logic [11:0] d, input logic [15:0] c,
                    input logic [4:0] er, input logic [2:0] b, input logic [2:0] a,
                    input logic [4:0] st, input logic p, input logic ps,
                    input logic [2:0] eb, input logic [2:0] ea);
      vec_t r;
      r = '{i, e, d, c, er, b, a, st, p, ps, eb, ea};
      tv.push_back(r);
   endtask

   task automatic chk_zero(input string n);
      chk({n, " state"}, 32'(state), 32'(S_R));
      chk({n, " pop"}, 32'(in_pop), 0);
      chk({n, " push"}, 32'(out_push), 0);
      chk({n, " data"}, 32'(out_data), 0);
      chk({n, " bajo"}, 32'(umbral_bajo), 0);
      chk({n, " alto"}, 32'(umbral_alto), 0);
      chk({n, " pause"}, 32'(pause), 0);
      chk({n, " idle"}, 32'(idle), 0);
      chk({n, " err"}, 32'(error_out), 0);
      chk({n, " cnt_out"}, 32'(counter_out), 0);
      chk({n, " cnt_val"}, 32'(counter_valid), 0);
   endtask

   initial begin
      vec_t r;
      sb_t  e;
      string n;
      rst_n = 1'b0; init = 1'b0; in_empty = 1'b1; in_data = '0; out_count = '0;
      fifo_error = '0; bajo_in = 3'd2; alto_in = 3'd7; idx = '0; req = 1'b0;

      //  init e  data    cnt      err    b  a  state pop pause eb ea
      v(1, 1, 12'h000, 16'h0000, 5'h00, 2, 7, S_R, 0, 0, 0, 0);
      v(1, 1, 12'h000, 16'h0000, 5'h00, 2, 7, S_I, 0, 1, 0, 0);
      v(0, 1, 12'h000, 16'h0000, 5'h00, 2, 7, S_I, 0, 1, 2, 7);
      v(0, 1, 12'h000, 16'h0000, 5'h00, 2, 7, S_D, 0, 0, 2, 7);
      v(0, 0, 12'h00F, 16'h0000, 5'h00, 2, 7, S_D, 0, 0, 2, 7);
      v(0, 0, 12'h00F, 16'h0000, 5'h00, 2, 7, S_A, 1, 0, 2, 7);
      v(0, 0, 12'h414, 16'h0000, 5'h00, 2, 7, S_A, 1, 0, 2, 7);
      v(0, 0, 12'h819, 16'h0000, 5'h00, 2, 7, S_A, 1, 0, 2, 7);
      v(0, 0, 12'hC1E, 16'h0000, 5'h00, 2, 7, S_A, 1, 0, 2, 7);
      v(0, 1, 12'hC1E, 16'h0000, 5'h00, 2, 7, S_A, 0, 0, 2, 7);
      v(0, 1, 12'hC1E, 16'h0000, 5'h00, 2, 7, S_A, 0, 0, 2, 7);
      v(0, 1, 12'h000, 16'h0000, 5'h00, 2, 7, S_D, 0, 0, 2, 7);
      v(0, 0, 12'h00F, 16'h0006, 5'h00, 2, 7, S_D, 0, 0, 2, 7);
      v(0, 0, 12'h00F, 16'h0006, 5'h00, 2, 7, S_A, 1, 0, 2, 7);
      v(0, 0, 12'h015, 16'h0006, 5'h00, 2, 7, S_A, 0, 0, 2, 7);
      v(0, 0, 12'h015, 16'h0007, 5'h00, 2, 7, S_A, 0, 0, 2, 7);
      v(0, 0, 12'h015, 16'h0007, 5'h00, 2, 7, S_A, 0, 1, 2, 7);
      v(0, 0, 12'h015, 16'h0003, 5'h00, 2, 7, S_A, 1, 1, 2, 7);
      v(0, 1, 12'h015, 16'h0003, 5'h00, 2, 7, S_A, 0, 1, 2, 7);
      v(0, 1, 12'h015, 16'h0002, 5'h00, 2, 7, S_A, 0, 1, 2, 7);
      v(0, 1, 12'h000, 16'h0002, 5'h00, 2, 7, S_D, 0, 0, 2, 7);
      v(0, 0, 12'h414, 16'h0000, 5'h00, 2, 7, S_D, 0, 0, 2, 7);
      v(0, 0, 12'h414, 16'h0000, 5'h04, 2, 7, S_A, 0, 0, 2, 7);
      v(1, 0, 12'h414, 16'h0000, 5'h04, 2, 7, S_E, 0, 0, 2, 7);
      v(1, 0, 12'h414, 16'h0000, 5'h00, 2, 7, S_E, 0, 0, 2, 7);
      v(1, 1, 12'h000, 16'h0000, 5'h00, 2, 7, S_I, 0, 0, 2, 7);
      v(0, 1, 12'h000, 16'h0000, 5'h00, 2, 7, S_I, 0, 0, 2, 7);
      v(0, 1, 12'h000, 16'h0000, 5'h00, 2, 7, S_D, 0, 0, 2, 7);
      v(1, 1, 12'h000, 16'h0000, 5'h00, 0, 0, S_D, 0, 0, 2, 7);
      v(0, 1, 12'h000, 16'h0000, 5'h00, 0, 0, S_I, 0, 0, 2, 7);
      v(0, 0, 12'h00F, 16'h0000, 5'h00, 0, 0, S_D, 0, 0, 0, 0);
      v(0, 0, 12'h00F, 16'h0000, 5'h00, 0, 0, S_A, 0, 1, 0, 0);
      v(0, 0, 12'h00F, 16'h0000, 5'h00, 0, 0, S_A, 0, 1, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      chk_zero("in_reset");
      rst_n = 1'b1;

      for (int i = 0; i < tv.size(); i++) begin
         r = tv[i];
         init = r.init; in_empty = r.empty; in_data = r.data; out_count = r.cnt;
         fifo_error = r.err; bajo_in = r.bajo; alto_in = r.alto;
         #1;
         n = $sformatf("row%0d", i);
         chk({n, " state"}, 32'(state), 32'(r.st));
         chk({n, " pop"}, 32'(in_pop), 32'(r.pop));
         chk({n, " pause"}, 32'(pause), 32'(r.pause));
         chk({n, " bajo"}, 32'(umbral_bajo), 32'(r.eb));
         chk({n, " alto"}, 32'(umbral_alto), 32'(r.ea));
         chk({n, " idle"}, 32'(idle), 32'(r.st == S_D && r.empty));
         chk({n, " err"}, 32'(error_out), 32'(r.st == S_E));
         chk({n, " cnt_val"}, 32'(counter_valid), 0);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({n, " push"}, 32'(out_push), 32'(e.push));
            chk({n, " data"}, 32'(out_data), 32'(e.data));
         end else
            chk({n, " push"}, 32'(out_push), 0);
         if (r.pop) begin
            e.push = 4'(1 << r.data[11:10]);
            e.data = r.data;
            sb.push_back(e);
         end
         tick();
      end

      // three words to P2, then read its push counter
      init = 1'b1; in_empty = 1'b1; out_count = '0; fifo_error = '0; bajo_in = 3'd2; alto_in = 3'd7;
      tick();
      tick();
      init = 1'b0;
      tick();
      in_empty = 1'b0; in_data = 12'h801;
      tick();
      chk("p2 state", 32'(state), 32'(S_A));
      chk("p2 pop0", 32'(in_pop), 1);
      tick();
      in_data = 12'h802;
      #1;
      chk("p2 push0", 32'(out_push), 32'h4);
      chk("p2 data0", 32'(out_data), 32'h801);
      chk("p2 pop1", 32'(in_pop), 1);
      tick();
      in_data = 12'h803;
      #1;
      chk("p2 push1", 32'(out_push), 32'h4);
      chk("p2 data1", 32'(out_data), 32'h802);
      tick();
      in_empty = 1'b1;
      #1;
      chk("p2 push2", 32'(out_push), 32'h4);
      chk("p2 data2", 32'(out_data), 32'h803);
      chk("p2 pop3", 32'(in_pop), 0);
      tick();
      req = 1'b1; idx = 2'd2;
      tick();
      req = 1'b0;
`ifdef TLC_STATS_EN
      chk("stats out", 32'(counter_out), 3);
      chk("stats valid", 32'(counter_valid), 1);
`else
      chk("stats out", 32'(counter_out), 0);
      chk("stats valid", 32'(counter_valid), 0);
`endif
      tick();
      chk("stats valid low", 32'(counter_valid), 0);
      chk("p2 idle", 32'(state), 32'(S_D));

      // async reset with a push pending
      in_empty = 1'b0; in_data = 12'hC1E;
      tick();
      tick();
      chk("pre_rst push", 32'(out_push), 32'h8);
      chk("pre_rst data", 32'(out_data), 32'hC1E);
      #1 rst_n = 1'b0;
      #1;
      chk_zero("mid_rst");
      in_empty = 1'b1;
      tick();
      rst_n = 1'b1;
      #1;
      chk("rel state", 32'(state), 32'(S_R));
      tick();
      chk("rel init", 32'(state), 32'(S_I));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
